// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the word-copy engine: widths, memory depth, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_copy_engine_pkg;

    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 85;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Word index counter with source/destination address adders and last-word detect.
// Latency: addresses are combinational from the registered index.
// Backpressure: none; the index only moves when the FSM pulses inc.
module mem_copy_addr_gen #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] src_base,
    input  logic [W-1:0] dst_base,
    input  logic [W-1:0] len_base,
    output logic [W-1:0] src_addr,
    output logic [W-1:0] dst_addr,
    output logic         last
);

    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;
    logic [W-1:0] idx_nxt;

    assign idx_nxt  = idx_q + W'(1);
    assign src_addr = src_base + idx_q;
    assign dst_addr = dst_base + idx_q;
    assign last     = (idx_nxt == len_base);

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/mem_copy_engine.sv
// Copies len words from src to dst in ascending order, one READ and one WRITE cycle per word.
// Latency: done 2*len+1 cycles after start, or 1 cycle for len==0 / range error.
// Backpressure: none; start is ignored while busy.
module mem_copy_engine #(
    parameter int DATA_W    = mem_copy_engine_pkg::DATA_W,
    parameter int MEM_DEPTH = mem_copy_engine_pkg::MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] src,
    input  logic [DATA_W-1:0] dst,
    input  logic [DATA_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);
    import mem_copy_engine_pkg::*;

    // Carry bit kept so src/dst near the top of the address space cannot wrap past the check.
    localparam logic [DATA_W:0] DEPTH_X = (DATA_W+1)'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              idx_clr, idx_inc, last;
    logic [DATA_W-1:0] src_addr, dst_addr;
    logic [DATA_W:0]   src_end, dst_end;
    logic              range_err;

    assign src_end   = {1'b0, src} + {1'b0, len};
    assign dst_end   = {1'b0, dst} + {1'b0, len};
    assign range_err = (src_end > DEPTH_X) || (dst_end > DEPTH_X);

    mem_copy_addr_gen #(.W(DATA_W)) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clr      (idx_clr),
        .inc      (idx_inc),
        .src_base (src_q),
        .dst_base (dst_q),
        .len_base (len_q),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last     (last)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        data_d  = data_q;
        err_d   = err_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        mem_A   = '0;
        mem_WD  = '0;
        mem_WE  = 1'b0;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        err     = (state_q == DONE) && err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    err_d   = range_err;
                    idx_clr = 1'b1;
                    state_d = (range_err || (len == '0)) ? DONE : READ;
                end
            end
            READ: begin
                mem_A   = src_addr;
                data_d  = mem_RD;
                state_d = WRITE;
            end
            WRITE: begin
                mem_A   = dst_addr;
                mem_WD  = data_q;
                mem_WE  = 1'b1;
                idx_inc = 1'b1;
                state_d = last ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: table of copy vectors plus hand-written busy-restart and reset-abort sequences.
module tb_mem_copy_engine;

    localparam int DW    = 32;
    localparam int DEPTH = 85;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] src, dst, len;
    logic          busy, done, err;
    logic [DW-1:0] mem_A, mem_WD, mem_RD;
    logic          mem_WE;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] sh  [0:DEPTH-1];
    logic          pre_we;
    logic [6:0]    pre_a;
    logic [DW-1:0] pre_d;
    int            cyc = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic [DW-1:0] s;
        logic [DW-1:0] d;
        logic [DW-1:0] l;
        int            kind;
        logic          exp_err;
    } vec_t;

    wr_t  wr_q[$];
    int   done_q[$];
    logic derr_q[$];
    vec_t vt[10];

    int checks   = 0;
    int failures = 0;
    int we_total = 0;

    mem_copy_engine #(.DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .mem_A  (mem_A),
        .mem_WD (mem_WD),
        .mem_WE (mem_WE),
        .mem_RD (mem_RD)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_RD = (mem_A < DW'(DEPTH)) ? mem[mem_A[6:0]] : '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (mem_WE && (mem_A < DW'(DEPTH))) begin
            mem[mem_A[6:0]] <= mem_WD;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (mem_WE) begin
            we_total++;
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write (cycle %0d)",
                         mem_A, mem_WD, cyc);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("write_addr", mem_A, w.a);
                chk("write_data", mem_WD, w.d);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no done (cycle %0d)", cyc);
            end else begin
                int   c;
                logic e;
                c = done_q.pop_front();
                e = derr_q.pop_front();
                chk("done_cycle", cyc, c);
                chk("done_err", err, e);
            end
        end else begin
            chk("err_without_done", err, 1'b0);
        end
        if (!busy || done) begin
            chk("idle_bus_quiet", {mem_A, mem_WD[30:0], mem_WE}, 64'h0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic preload(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] v;
            v = DW'(i + 1);
            if (kind == 1 && i == 0) v = 32'd7;
            if (kind == 1 && i == 1) v = 32'd9;
            if (kind == 2 && i >= 10 && i <= 13) v = 32'hDEAD;
            sh[i]  = v;
            pre_we = 1'b1;
            pre_a  = 7'(i);
            pre_d  = v;
            tick();
        end
        pre_we = 1'b0;
        tick();
    endtask

    // Preloads memory, queues the expected writes and done, and pulses start; returns the start cycle.
    task automatic launch(input logic [DW-1:0] s, input logic [DW-1:0] d, input logic [DW-1:0] l,
                          input int kind, input logic exp_err, output int n0);
        int lat;
        preload(kind);
        if (!exp_err) begin
            for (int i = 0; i < int'(l); i++) begin
                wr_t w;
                sh[int'(d) + i] = sh[int'(s) + i];
                w.a = d + DW'(i);
                w.d = sh[int'(d) + i];
                wr_q.push_back(w);
            end
        end
        lat = (exp_err || l == 0) ? 1 : 2 * int'(l) + 1;
        n0  = cyc;
        done_q.push_back(n0 + lat);
        derr_q.push_back(exp_err);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        tick();
        start = 1'b0;
        src   = $urandom;
        dst   = $urandom;
        len   = $urandom;
    endtask

    task automatic finish_copy(input int we0, input int exp_we, input string tag);
        int budget;
        int mism;
        budget = 0;
        while (done_q.size() != 0 && budget < 400) begin
            tick();
            budget++;
        end
        if (done_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no done required=done within 400 cycles", tag);
            done_q.delete();
            derr_q.delete();
        end
        for (int i = 0; i < 4; i++) tick();
        chk({tag, "_pending_writes"}, wr_q.size(), 0);
        wr_q.delete();
        chk({tag, "_we_count"}, we_total - we0, exp_we);
        chk({tag, "_busy_after"}, busy, 1'b0);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== sh[i]) mism++;
        chk({tag, "_mem_image_mismatches"}, mism, 0);
    endtask

    initial begin
        int n0;
        int we0;

        vt[0] = '{s: 32'd0,          d: 32'd10, l: 32'd4,  kind: 0, exp_err: 1'b0};
        vt[1] = '{s: 32'd5,          d: 32'd20, l: 32'd0,  kind: 0, exp_err: 1'b0};
        vt[2] = '{s: 32'd80,         d: 32'd0,  l: 32'd6,  kind: 0, exp_err: 1'b1};
        vt[3] = '{s: 32'd0,          d: 32'd1,  l: 32'd3,  kind: 1, exp_err: 1'b0};
        vt[4] = '{s: 32'd0,          d: 32'd80, l: 32'd5,  kind: 0, exp_err: 1'b0};
        vt[5] = '{s: 32'd0,          d: 32'd81, l: 32'd5,  kind: 0, exp_err: 1'b1};
        vt[6] = '{s: 32'd84,         d: 32'd3,  l: 32'd1,  kind: 0, exp_err: 1'b0};
        vt[7] = '{s: 32'hFFFF_FFFF,  d: 32'd0,  l: 32'd2,  kind: 0, exp_err: 1'b1};
        vt[8] = '{s: 32'd30,         d: 32'd20, l: 32'd15, kind: 0, exp_err: 1'b0};
        vt[9] = '{s: 32'd0,          d: 32'd0,  l: 32'd86, kind: 0, exp_err: 1'b1};

        reset  = 1'b0;
        start  = 1'b0;
        src    = '0;
        dst    = '0;
        len    = '0;
        pre_we = 1'b0;
        pre_a  = '0;
        pre_d  = '0;
        #3;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done_err", {done, err}, 2'b00);
        chk("reset_mem_bus", {mem_A, mem_WD, mem_WE}, 65'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int v = 0; v < 10; v++) begin
            we0 = we_total;
            launch(vt[v].s, vt[v].d, vt[v].l, vt[v].kind, vt[v].exp_err, n0);
            finish_copy(we0, vt[v].exp_err ? 0 : int'(vt[v].l), $sformatf("vec%0d", v));
            if (v == 0) begin
                for (int i = 0; i < 4; i++) chk("copy4_dst_word", mem[10 + i], 32'(i + 1));
            end
            if (v == 3) begin
                for (int i = 1; i < 4; i++) chk("overlap_word", mem[i], 32'd7);
            end
        end

        // Second start while busy must be ignored.
        we0 = we_total;
        launch(32'd0, 32'd10, 32'd4, 0, 1'b0, n0);
        while (cyc < n0 + 3) tick();
        start = 1'b1;
        src   = 32'd40;
        dst   = 32'd50;
        len   = 32'd2;
        tick();
        start = 1'b0;
        finish_copy(we0, 4, "busy_restart");

        // Reset asserted during the WRITE of word 1 aborts the copy.
        we0 = we_total;
        launch(32'd0, 32'd10, 32'd4, 2, 1'b0, n0);
        while (cyc < n0 + 3) tick();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_we", mem_WE, 1'b0);
        chk("abort_bus", {mem_A, mem_WD, done, err}, 66'h0);
        wr_q.delete();
        done_q.delete();
        derr_q.delete();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_we_count", we_total - we0, 1);
        chk("abort_word0", mem[10], 32'd1);
        for (int i = 11; i < 14; i++) chk("abort_untouched", mem[i], 32'hDEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
